tart_antenna_gen: RTL and testbench
===================================

TART_ANTENNA_GEN -- requirements
Module: tart_antenna_gen

Interface
REQ-001 Parameter WIDTH, default 24, number of antenna channels (pattern width).
REQ-002 Parameter RBITS, default 4, width of the sample-rate divider.
REQ-003 Parameter MRATE, default 12, reset value of the divider period, in clocks.
REQ-004 Port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-005 Port rst_i, input, 1, reset; synchronous, active-high.
REQ-006 Ports cyc_i, stb_i and we_i, input, 1 each, Wishbone classic slave strobes.
REQ-007 Port adr_i, input, 2, register select.
REQ-008 Port dat_i, input, 8, write data.
REQ-009 Port dat_o, output, 8, read data.
REQ-010 Port ack_o, output, 1, transfer acknowledge.
REQ-011 Port antenna_o, output, WIDTH, generated antenna sample.
REQ-012 Port strobe_o, output, 1, one-cycle pulse; antenna_o holds a new value on that cycle.
REQ-013 Port enabled_o, output, 1, copy of CTRL.enable.

Function
REQ-014 Registers:
- adr 0, CTRL: bit0 enable, bits2:1 mode.
- adr 1, RATE: divider period minus 1, low RBITS bits used.
- adr 2, SEED: 8-bit seed/constant.
- adr 3, COUNT: read-only, low 8 bits of the sample counter.
REQ-015 Bus handshake:
- ack_o asserts exactly 1 clock after cyc_i && stb_i, provided ack_o is low.
- ack_o is a one-cycle pulse; back-to-back strobes are therefore acked every 2nd cycle.
- A write takes effect on the acking edge.
REQ-016 dat_o carries the selected register while ack_o is high, and 0 otherwise.
REQ-017 Divider counter cnt:
- enabled: 0..RATE, wrapping to 0.
- disabled: held at 0.
REQ-018 strobe_o asserts on the cycle after cnt==RATE while enabled, so there is one strobe every RATE+1 clocks; RATE=0 strobes every clock.
REQ-019 On each strobe the pattern advances according to mode:
- 0, counter: +1 modulo 2^WIDTH.
- 1, LFSR: Galois right-shift with WIDTH-dependent maximal taps; an all-zero state loads 1.
- 2, walking-one: rotate left by 1.
- 3, constant: SEED replicated across WIDTH, truncated at the MSB.
REQ-020 A write to CTRL or SEED reloads the pattern on the next cycle and clears cnt:
- modes 0 and 1: pattern = SEED, zero-extended.
- mode 2: pattern = 1 << (SEED mod WIDTH).
- mode 3: pattern = replicated SEED.
REQ-021 The sample counter increments on each strobe, wraps at 2^16, and is cleared by any CTRL write.
REQ-022 A RATE write while enabled clears cnt; the next strobe follows RATE+1 clocks after the write ack.
REQ-023 If a strobe and a reload fall on the same cycle, the reload wins and no strobe is emitted.
REQ-024 antenna_o holds its value while disabled; strobe_o stays 0 while disabled.

Reset
REQ-025 rst_i high, on any clock edge and mid-transfer, sets the following; an in-flight bus cycle is not acked:
- CTRL=0, RATE=MRATE-1, SEED=0.
- cnt=0, sample counter=0, antenna_o=0.
- strobe_o=0, ack_o=0, dat_o=0, enabled_o=0.

Configuration
REQ-026 Macro TART_GEN_LFSR_EN:
- defined: mode 1 behaves per REQ-019.
- undefined: no LFSR logic exists and mode 1 behaves exactly as mode 0.

Verification
REQ-027 Reset, then read all 4 registers -> 0x00, 0x0B, 0x00, 0x00; each ack arrives 1 cycle after stb.
REQ-028 Write RATE=3, SEED=5, CTRL=0x01 -> strobe_o every 4 clocks; antenna_o sequence 6, 7, 8; COUNT reads 3 after 3 strobes.
REQ-029 WIDTH=24, SEED=0xFF, counter mode, run 2^24 strobes at RATE=0 -> antenna_o wraps 0xFFFFFF to 0x000000 with no glitch.
REQ-030 Walking-one (CTRL=0x05) with SEED=23 -> 0x800000 then 0x000001; constant mode (CTRL=0x07) with SEED=0xA5 -> 0xA5A5A5, unchanged across strobes.
REQ-031 LFSR mode with SEED=0 -> state loaded to 1, never all-zero over 1000 strobes; build without TART_GEN_LFSR_EN -> same stimulus gives counter output 1, 2, 3.
REQ-032 Assert rst_i during an active read and while enabled -> no ack; every output matches REQ-025 on the next cycle.

Source files
------------

// File: rtl/tart_antenna_gen.sv
// tart_antenna_gen: Wishbone-programmed antenna pattern source for TART.
// Latency: ack_o and dat_o 1 clk after cyc_i&&stb_i. A CTRL/SEED write reloads the pattern 1 clk after its ack.
// Backpressure: none; the bus is acked every 2nd clk at most, and the pattern free-runs at the divider rate.
// Ports: clk_i/rst_i (sync, active-high); cyc_i/stb_i/we_i/adr_i/dat_i/dat_o/ack_o classic WB slave;
//        antenna_o pattern, strobe_o one-clk "new sample" pulse, enabled_o = CTRL.enable.
// Optional macro TART_GEN_LFSR_EN: when defined, mode 1 is a Galois LFSR; otherwise mode 1 is the counter.
module tart_antenna_gen #(
  parameter int WIDTH = 24,
  parameter int RBITS = 4,
  parameter int MRATE = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [1:0]       adr_i,
  input  logic [7:0]       dat_i,
  output logic [7:0]       dat_o,
  output logic             ack_o,
  output logic [WIDTH-1:0] antenna_o,
  output logic             strobe_o,
  output logic             enabled_o
);

  localparam logic [RBITS-1:0] RATE_RST = RBITS'(MRATE - 1);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  // SEED repeated byte-wise across the pattern, MSB end truncated.
  function automatic logic [WIDTH-1:0] replicate(input logic [7:0] s);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = s[i[2:0]];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] walk_load(input logic [7:0] s);
    return ONE << (int'(s) % WIDTH);
  endfunction

`ifdef TART_GEN_LFSR_EN
  // Right-shift Galois masks for maximal-length sequences; unlisted widths
  // fall back to a single MSB tap (still never locks up, but not maximal).
  function automatic logic [WIDTH-1:0] lfsr_taps();
    logic [63:0] t;
    case (WIDTH)
      4:       t = 64'hC;
      8:       t = 64'hB8;
      12:      t = 64'hE08;
      16:      t = 64'hB400;
      20:      t = 64'h90000;
      24:      t = 64'hE10000;
      32:      t = 64'h80200003;
      default: t = 64'h1 << (WIDTH - 1);
    endcase
    return t[WIDTH-1:0];
  endfunction
  localparam logic [WIDTH-1:0] LFSR_TAPS = lfsr_taps();
`endif

  logic [2:0]       ctrl_q, ctrl_d;
  logic [RBITS-1:0] rate_q, rate_d, cnt_q, cnt_d;
  logic [7:0]       seed_q, seed_d, dat_q, dat_d;
  logic [15:0]      count_q, count_d;
  logic [WIDTH-1:0] pat_q, pat_d, adv, reload_val;
  logic             strobe_q, strobe_d, ack_q, ack_d, reload_q, reload_d;
  logic             req, wr, ctrl_wr, rate_wr, seed_wr, en, hit;
  logic [7:0]       rd_mux;

  // Pattern step on a strobe, and the value loaded after a CTRL/SEED write.
  always_comb begin
    adv        = pat_q;
    reload_val = replicate(seed_q);
    case (ctrl_q[2:1])
      2'd0: begin
        adv        = pat_q + ONE;
        reload_val = WIDTH'(seed_q);
      end
      2'd1: begin
`ifdef TART_GEN_LFSR_EN
        adv = (pat_q == '0) ? ONE : ((pat_q >> 1) ^ (pat_q[0] ? LFSR_TAPS : '0));
`else
        adv = pat_q + ONE;
`endif
        reload_val = WIDTH'(seed_q);
      end
      2'd2: begin
        adv        = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
        reload_val = walk_load(seed_q);
      end
      default: begin
        adv        = replicate(seed_q);
        reload_val = replicate(seed_q);
      end
    endcase
  end

  always_comb begin
    // Only the first cycle of a strobe is a transfer; the acking cycle is not.
    req     = cyc_i && stb_i && !ack_q;
    wr      = req && we_i;
    ctrl_wr = wr && (adr_i == 2'd0);
    rate_wr = wr && (adr_i == 2'd1);
    seed_wr = wr && (adr_i == 2'd2);
    en      = ctrl_q[0];
    hit     = en && (cnt_q == rate_q);

    case (adr_i)
      2'd0:    rd_mux = {5'd0, ctrl_q};
      2'd1:    rd_mux = 8'(rate_q);
      2'd2:    rd_mux = seed_q;
      default: rd_mux = count_q[7:0];
    endcase

    ctrl_d   = ctrl_wr ? dat_i[2:0] : ctrl_q;
    rate_d   = rate_wr ? RBITS'(dat_i) : rate_q;
    seed_d   = seed_wr ? dat_i : seed_q;
    reload_d = ctrl_wr || seed_wr;

    // A pending reload swallows a strobe that would land on the same edge.
    strobe_d = hit && !reload_q;

    if (!en || reload_q || rate_wr || hit) cnt_d = '0;
    else                                   cnt_d = cnt_q + RBITS'(1);

    if (reload_q)      pat_d = reload_val;
    else if (strobe_d) pat_d = adv;
    else               pat_d = pat_q;

    if (ctrl_wr)       count_d = '0;
    else if (strobe_d) count_d = count_q + 16'd1;
    else               count_d = count_q;

    ack_d = req;
    dat_d = req ? rd_mux : 8'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q   <= '0;
      rate_q   <= RATE_RST;
      seed_q   <= '0;
      cnt_q    <= '0;
      count_q  <= '0;
      pat_q    <= '0;
      strobe_q <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      reload_q <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      rate_q   <= rate_d;
      seed_q   <= seed_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      pat_q    <= pat_d;
      strobe_q <= strobe_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      reload_q <= reload_d;
    end
  end

  assign dat_o     = dat_q;
  assign ack_o     = ack_q;
  assign antenna_o = pat_q;
  assign strobe_o  = strobe_q;
  assign enabled_o = ctrl_q[0];

endmodule

// File: tb/tb_tart_antenna_gen.sv
// Bench for tart_antenna_gen: bus reads and antenna samples are predicted
// into queues by the stimulus and popped by an independent monitor.
module tb_tart_antenna_gen;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [1:0]  adr_i = 2'd0;
  logic [7:0]  dat_i = 8'd0;
  logic [7:0]  dat_o;
  logic        ack_o;
  logic [23:0] antenna_o;
  logic        strobe_o;
  logic        enabled_o;

  int checks = 0, failures = 0;
  int cyc_n = 0;
  logic [23:0] ant_q[$];
  logic [7:0]  rd_q[$];
  int cfg_id = 0, exp_period = 1;
  bit per_chk = 1'b1;
  int last_ack = 0, e_edge = 0;
  int mon_cfg = -1, mon_last = 0;

  tart_antenna_gen #(.WIDTH(24), .RBITS(4), .MRATE(12)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
    .antenna_o(antenna_o), .strobe_o(strobe_o), .enabled_o(enabled_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", nm, act, exp, cyc_n);
    end
  endtask

  // Monitor: consumes expected read data on read acks and expected samples on strobes.
  always @(negedge clk_i) begin
    if (ack_o && !we_i) begin
      if (rd_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_read_ack actual=0x%0h required=none", dat_o);
      end else chk("read_data", dat_o, rd_q.pop_front());
    end
    if (!ack_o && !rst_i) chk("dat_idle", dat_o, 0);
    if (strobe_o) begin
      if (ant_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_strobe actual=0x%0h required=no_strobe cycle=%0d", antenna_o, cyc_n);
      end else chk("antenna", antenna_o, ant_q.pop_front());
      if (per_chk && mon_cfg == cfg_id) chk("strobe_period", cyc_n - mon_last, exp_period);
      mon_cfg  = cfg_id;
      mon_last = cyc_n;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic xfer(input logic w, input logic [1:0] a, input logic [7:0] d);
    int n;
    @(posedge clk_i); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d;
    n = 0;
    do begin @(posedge clk_i); #1; n++; end while (!ack_o && n < 8);
    last_ack = cyc_n;
    chk("ack_latency", n, 1);
    cyc_i = 1'b0; stb_i = 1'b0;  // we_i/adr_i held so the monitor can classify the ack
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp);
    rd_q.push_back(exp);
    xfer(1'b0, a, 8'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    xfer(1'b1, a, d);
  endtask

  // Reference: pattern after k strobes, from the mode rules directly.
  task automatic cfg_start(input int mode, input int rate, input logic [7:0] seed, input int npush);
    logic [23:0] v, one, rel;
    one = 24'd1;
    cfg_id++;
    exp_period = rate + 1;
    wr(2'd1, 8'(rate));
    wr(2'd2, seed);
    v = {16'd0, seed};
    for (int k = 1; k <= npush; k++) begin
      case (mode)
        1: begin
`ifdef TART_GEN_LFSR_EN
          if (v == 24'd0) v = 24'd1;
          else v = v[0] ? ((v >> 1) ^ 24'hE10000) : (v >> 1);
          ant_q.push_back(v);
`else
          ant_q.push_back(24'(int'(seed) + k));
`endif
        end
        2: ant_q.push_back(one << ((int'(seed) % 24 + k) % 24));
        3: ant_q.push_back({seed, seed, seed});
        default: ant_q.push_back(24'(int'(seed) + k));
      endcase
    end
    case (mode)
      2: rel = one << (int'(seed) % 24);
      3: rel = {seed, seed, seed};
      default: rel = {16'd0, seed};
    endcase
    wr(2'd0, 8'((mode << 1) | 1));
    e_edge = last_ack;
    chk("enabled_on", enabled_o, 1);
    @(posedge clk_i); #1;
    chk("reload_value", antenna_o, rel);
  endtask

  // Runs exactly K strobes before reading COUNT, then disables and checks
  // that the number of strobes seen matches the elapsed time.
  task automatic cfg_finish(input int mode, input int rate, input logic [7:0] seed,
                            input int k, input int npush);
    int d, n;
    repeat (k * (rate + 1) - 1) @(posedge clk_i);
    rd(2'd3, 8'(k));
    rd(2'd0, 8'((mode << 1) | 1));
    rd(2'd1, 8'(rate));
    rd(2'd2, seed);
    wr(2'd0, 8'd0);
    d = last_ack;
    @(negedge clk_i); #1;
    n = (d - e_edge - 1) / (rate + 1);
    chk("strobe_count", ant_q.size(), npush - n);
    chk("enabled_off", enabled_o, 0);
    ant_q.delete();
  endtask

  task automatic run(input int mode, input int rate, input logic [7:0] seed, input int k);
    cfg_start(mode, rate, seed, k + 12);
    cfg_finish(mode, rate, seed, k, k + 12);
  endtask

  task automatic wait_strobe(output int t);
    bit found;
    found = 1'b0;
    t = -1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk_i);
      if (strobe_o) begin found = 1'b1; t = cyc_n; end
    end
  endtask

  initial begin
    int w, t1, t2;
    // Reset state
    repeat (3) @(posedge clk_i); #1;
    chk("rst_ack", ack_o, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_antenna", antenna_o, 0);
    chk("rst_strobe", strobe_o, 0);
    chk("rst_enabled", enabled_o, 0);
    rst_i = 1'b0;
    rd(2'd0, 8'h00); rd(2'd1, 8'h0B); rd(2'd2, 8'h00); rd(2'd3, 8'h00);

    // Directed patterns
    run(0, 3, 8'd5, 3);       // 6,7,8 every 4 clocks, COUNT=3
    run(2, 1, 8'd23, 4);      // 0x800000 then 0x000001...
    run(2, 0, 8'd30, 30);     // bit index wraps 23 -> 0
    run(3, 2, 8'hA5, 4);      // constant 0xA5A5A5
    run(0, 0, 8'hFF, 5);      // carry out of the seed byte
    run(1, 0, 8'd0, 1000);    // zero seed in mode 1, 1000 strobes

    // Randomized configurations
    for (int i = 0; i < 8; i++)
      run($urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom_range(0, 255)),
          $urandom_range(2, 8));

    // RATE rewrite while enabled restarts the divider
    cfg_start(3, 5, 8'h5A, 40);
    per_chk = 1'b0;
    repeat (2) @(posedge clk_i);
    wr(2'd1, 8'd2);
    w = last_ack;
    wait_strobe(t1);
    chk("rate_wr_first_gap", t1 - w, 3);
    wait_strobe(t2);
    chk("rate_wr_next_gap", t2 - t1, 3);
    wr(2'd0, 8'd0);
    @(negedge clk_i); #1;
    ant_q.delete();
    per_chk = 1'b1;

    // Reset during an active read while enabled
    cfg_start(3, 1, 8'h3C, 60);
    repeat (5) @(posedge clk_i);
    @(posedge clk_i); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 2'd3; rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("midrst_ack", ack_o, 0);
    chk("midrst_dat", dat_o, 0);
    chk("midrst_antenna", antenna_o, 0);
    chk("midrst_strobe", strobe_o, 0);
    chk("midrst_enabled", enabled_o, 0);
    cyc_i = 1'b0; stb_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    ant_q.delete();
    cfg_id++;
    repeat (20) @(posedge clk_i);
    rd(2'd0, 8'h00); rd(2'd1, 8'h0B); rd(2'd2, 8'h00); rd(2'd3, 8'h00);
    @(negedge clk_i); #1;
    chk("reads_drained", rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
